// File: rtl/console_mem_pkg.sv
// Shared definitions for console memory clients: latency presets, reader FSM
// states and a constant-foldable ceil(log2) helper.
package console_mem_pkg;

  localparam int LAT_HIGH_PERF = 2;
  localparam int LAT_LOW_LAT   = 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } reader_state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_fwft.sv
// Show-ahead synchronous FIFO: head always presents the oldest entry, and a
// push and a pop may share a cycle even when the FIFO is full.
module sync_fifo_fwft
  import console_mem_pkg::*;
#(
  parameter int WIDTH = 19,
  parameter int DEPTH = 4,
  localparam int CNT_W = clog2(DEPTH + 1),
  localparam int PTR_W = (DEPTH > 1) ? clog2(DEPTH) : 1
) (
  input  logic             clka,
  input  logic             rstb,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Pointers wrap explicitly so non-power-of-two depths work.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clka) begin
    if (rstb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clka) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/bram_stream_reader.sv
// Streams a (start, length) run of words out of one BRAM read port as a
// valid/ready stream, using credits so in-flight reads always find FIFO room.
module bram_stream_reader
  import console_mem_pkg::*;
#(
  parameter int RAM_WIDTH    = 18,
  parameter int RAM_DEPTH    = 1024,
  parameter int READ_LATENCY = LAT_HIGH_PERF,
  parameter int FIFO_DEPTH   = 4,
  localparam int ADDR_W      = clog2(RAM_DEPTH)
) (
  input  logic                 clka,
  input  logic                 rstb,
  input  logic                 start_valid,
  output logic                 start_ready,
  input  logic [ADDR_W-1:0]    start_addr,
  input  logic [ADDR_W:0]      start_len,
  output logic                 ram_en,
  output logic [ADDR_W-1:0]    ram_addr,
  output logic                 ram_regce,
  output logic                 ram_rst,
  input  logic [RAM_WIDTH-1:0] ram_dout,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [RAM_WIDTH-1:0] m_data,
  output logic                 m_last,
  output logic                 busy,
  output logic                 done
);

  localparam int CNT_W = clog2(FIFO_DEPTH + 1);

  if ((READ_LATENCY < 1) || (FIFO_DEPTH < READ_LATENCY + 1)) begin : g_param_check
    $error("bram_stream_reader: need READ_LATENCY >= 1 and FIFO_DEPTH >= READ_LATENCY+1");
  end

  reader_state_t             state;
  logic [ADDR_W-1:0]         cur_addr;
  logic [ADDR_W:0]           remaining;
  logic                      ram_last;
  logic                      zero_done;
  logic [READ_LATENCY-1:0]   vld_p;
  logic [READ_LATENCY-1:0]   last_p;
  logic [RAM_WIDTH:0]        fifo_head;
  logic                      fifo_empty;
  logic [CNT_W-1:0]          fifo_count;
  logic [CNT_W-1:0]          in_flight;
  logic [CNT_W-1:0]          credits;
  logic                      accept;
  logic                      hs;
  logic                      issue_go;

  function automatic logic [ADDR_W-1:0] next_addr(input logic [ADDR_W-1:0] a);
    return (a == ADDR_W'(RAM_DEPTH - 1)) ? '0 : a + 1'b1;
  endfunction

  assign ram_regce = ~rstb;
  assign ram_rst   = rstb;

  assign busy        = (state != IDLE) || zero_done;
  assign start_ready = ~busy;
  assign accept      = start_valid && start_ready;

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_empty ? '0 : fifo_head[RAM_WIDTH-1:0];
  assign m_last  = ~fifo_empty && fifo_head[RAM_WIDTH];
  assign hs      = m_valid && m_ready;
  assign done    = zero_done || ((state == DRAIN) && hs && m_last);

  // A read is owed a FIFO slot from the moment it is scheduled: the pending
  // ram_en, every tag still in the latency pipe, and every queued word.
  always_comb begin
    in_flight = CNT_W'(ram_en);
    for (int i = 0; i < READ_LATENCY; i++) begin
      in_flight = in_flight + CNT_W'(vld_p[i]);
    end
    credits = CNT_W'(FIFO_DEPTH) - in_flight - fifo_count;
  end

  assign issue_go = (state == ISSUE) && ((credits != '0) || hs);

  // ---- stage p0: command FSM and read issue ----
  always_ff @(posedge clka) begin
    if (rstb) begin
      state     <= IDLE;
      ram_en    <= 1'b0;
      ram_addr  <= '0;
      ram_last  <= 1'b0;
      cur_addr  <= '0;
      remaining <= '0;
      zero_done <= 1'b0;
    end else begin
      zero_done <= 1'b0;
      ram_en    <= 1'b0;
      ram_last  <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            if (start_len == '0) begin
              zero_done <= 1'b1;
            end else begin
              ram_en    <= 1'b1;
              ram_addr  <= start_addr;
              ram_last  <= (start_len == (ADDR_W + 1)'(1));
              cur_addr  <= next_addr(start_addr);
              remaining <= start_len - 1'b1;
              state     <= (start_len == (ADDR_W + 1)'(1)) ? DRAIN : ISSUE;
            end
          end
        end
        ISSUE: begin
          if (issue_go) begin
            ram_en    <= 1'b1;
            ram_addr  <= cur_addr;
            ram_last  <= (remaining == (ADDR_W + 1)'(1));
            cur_addr  <= next_addr(cur_addr);
            remaining <= remaining - 1'b1;
            if (remaining == (ADDR_W + 1)'(1)) state <= DRAIN;
          end
        end
        DRAIN: begin
          if (hs && m_last) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- stages p1..pN: latency tags travelling beside the BRAM read ----
  always_ff @(posedge clka) begin
    if (rstb) begin
      vld_p  <= '0;
      last_p <= '0;
    end else begin
      vld_p[0]  <= ram_en;
      last_p[0] <= ram_last;
      for (int i = 1; i < READ_LATENCY; i++) begin
        vld_p[i]  <= vld_p[i-1];
        last_p[i] <= last_p[i-1];
      end
    end
  end

  // ---- output stage: skid FIFO ----
  sync_fifo_fwft #(
    .WIDTH (RAM_WIDTH + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clka      (clka),
    .rstb      (rstb),
    .push      (vld_p[READ_LATENCY-1]),
    .push_data ({last_p[READ_LATENCY-1], ram_dout}),
    .pop       (hs),
    .head      (fifo_head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader: a queue model of the expected read
// addresses and output words is checked every cycle, plus literal timing/data pins.
module tb_bram_stream_reader;

  localparam int RW = 18;
  localparam int DEPTH = 1024;
  localparam int AW = 10;
  localparam int LW = AW + 1;
  localparam int FD = 4;

  logic clka = 1'b0;
  logic rstb = 1'b1;

  logic          start_valid = 1'b0;
  logic          start_ready;
  logic [AW-1:0] start_addr = '0;
  logic [AW:0]   start_len = '0;
  logic          ram_en, ram_regce, ram_rst;
  logic [AW-1:0] ram_addr;
  logic [RW-1:0] ram_dout = '0;
  logic [RW-1:0] bram_p1 = '0;
  logic          m_valid, m_last, busy, done;
  logic          m_ready = 1'b1;
  logic [RW-1:0] m_data;

  logic          start_valid_1 = 1'b0;
  logic          start_ready_1;
  logic [AW-1:0] start_addr_1 = '0;
  logic [AW:0]   start_len_1 = '0;
  logic          ram_en_1, ram_regce_1, ram_rst_1;
  logic [AW-1:0] ram_addr_1;
  logic [RW-1:0] ram_dout_1 = '0;
  logic          m_valid_1, m_last_1, busy_1, done_1;
  logic          m_ready_1 = 1'b1;
  logic [RW-1:0] m_data_1;

  int tests = 0;
  int fails = 0;

  logic [RW:0]   exp_q[$];
  int            exp_addr_q[$];
  int            addr_seen[$];
  logic [RW-1:0] got[$];
  bit            zero_pending = 1'b0;
  bit            busy_exp = 1'b0;
  bit            rnd_mode = 1'b0;
  int            issued = 0;
  int            hs_cnt = 0;
  logic          e_last, e_done;

  always #5 clka = ~clka;

  bram_stream_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(2), .FIFO_DEPTH(FD)) dut (
    .clka(clka), .rstb(rstb), .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_len(start_len), .ram_en(ram_en), .ram_addr(ram_addr),
    .ram_regce(ram_regce), .ram_rst(ram_rst), .ram_dout(ram_dout), .m_valid(m_valid),
    .m_ready(m_ready), .m_data(m_data), .m_last(m_last), .busy(busy), .done(done));

  bram_stream_reader #(.RAM_WIDTH(RW), .RAM_DEPTH(DEPTH), .READ_LATENCY(1), .FIFO_DEPTH(FD)) dut1 (
    .clka(clka), .rstb(rstb), .start_valid(start_valid_1), .start_ready(start_ready_1),
    .start_addr(start_addr_1), .start_len(start_len_1), .ram_en(ram_en_1), .ram_addr(ram_addr_1),
    .ram_regce(ram_regce_1), .ram_rst(ram_rst_1), .ram_dout(ram_dout_1), .m_valid(m_valid_1),
    .m_ready(m_ready_1), .m_data(m_data_1), .m_last(m_last_1), .busy(busy_1), .done(done_1));

  function automatic logic [RW-1:0] memval(input int i);
    return RW'(i) ^ 18'h2A5A5;
  endfunction

  // BRAM models: two-stage (array + output register) and single-stage.
  always @(posedge clka) begin
    if (ram_en) bram_p1 <= memval(int'(ram_addr));
    if (ram_rst) ram_dout <= '0;
    else if (ram_regce) ram_dout <= bram_p1;
    if (ram_rst_1) ram_dout_1 <= '0;
    else if (ram_en_1) ram_dout_1 <= memval(int'(ram_addr_1));
  end

  always @(posedge clka) begin
    #1;
    m_ready = rnd_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Per-cycle comparison of the DUT against the queue model.
  always @(negedge clka) begin
    if (rstb) begin
      exp_q.delete();
      exp_addr_q.delete();
      zero_pending = 1'b0;
      busy_exp = 1'b0;
      issued = 0;
      hs_cnt = 0;
    end else begin
      chk("ram_regce", ram_regce, 1);
      chk("ram_rst", ram_rst, 0);
      if (ram_en) begin
        addr_seen.push_back(int'(ram_addr));
        if (exp_addr_q.size() == 0) chk("unexpected_ram_en", ram_en, 0);
        else chk("ram_addr", ram_addr, exp_addr_q.pop_front());
        issued++;
        chk("outstanding_le_depth", (issued - hs_cnt) <= FD, 1);
      end
      e_last = 1'b0;
      if (m_valid) begin
        if (exp_q.size() == 0) chk("unexpected_m_valid", m_valid, 0);
        else begin
          chk("m_data", m_data, exp_q[0][RW-1:0]);
          chk("m_last", m_last, exp_q[0][RW]);
          e_last = exp_q[0][RW];
          if (m_ready) begin
            void'(exp_q.pop_front());
            hs_cnt++;
          end
        end
      end
      e_done = zero_pending || (m_valid && m_ready && e_last);
      chk("done", done, e_done);
      chk("busy", busy, busy_exp);
      chk("start_ready", start_ready, !busy_exp);
      if (e_done) busy_exp = 1'b0;
      zero_pending = 1'b0;
    end
  end

  task automatic run_cmd(input int a, input int l, input int hold, input int bound,
                         input int stop_after, output int fe, output int fv, output int dc);
    int w;
    fe = -1; fv = -1; dc = -1; w = 0;
    got.delete();
    addr_seen.delete();
    while (!start_ready && w < 200) begin
      @(posedge clka); #1; w++;
    end
    chk("start_ready_before_cmd", start_ready, 1);
    start_valid = 1'b1;
    start_addr = AW'(a);
    start_len = LW'(l);
    @(posedge clka);
    for (int i = 0; i < l; i++) begin
      exp_addr_q.push_back((a + i) % DEPTH);
      exp_q.push_back({(i == l - 1), memval((a + i) % DEPTH)});
    end
    if (l == 0) zero_pending = 1'b1;
    busy_exp = 1'b1;
    #1;
    start_valid = (hold > 0);
    start_addr = AW'(a + 333);
    start_len = LW'(5);
    for (int c = 1; c <= bound; c++) begin
      @(negedge clka);
      if (c >= hold) start_valid = 1'b0;
      if (ram_en && fe < 0) fe = c;
      if (m_valid && fv < 0) fv = c;
      if (m_valid && m_ready) got.push_back(m_data);
      if (done && dc < 0) dc = c;
      if (stop_after > 0 && got.size() == stop_after) break;
      if (dc >= 0 && c >= dc + 3) break;
    end
    start_valid = 1'b0;
    if (stop_after == 0) chk("done_within_bound", dc >= 0, 1);
  endtask

  initial begin
    int fe, fv, dc;
    int fv1, nv, lastv, dc1, nlast, lastk, n_bad;
    int wrap_exp[8];
    wrap_exp = '{1020, 1021, 1022, 1023, 0, 1, 2, 3};

    repeat (3) @(posedge clka);
    #1 rstb = 1'b0;
    @(negedge clka);
    chk("rst_start_ready", start_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ram_en", ram_en, 0);
    chk("rst_ram_addr", ram_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_start_ready_1", start_ready_1, 1);
    chk("rst_ram_regce_1", ram_regce_1, 1);

    // Basic run, with start_valid held during busy to prove it is ignored.
    run_cmd(10, 8, 2, 60, 0, fe, fv, dc);
    chk("t1_first_ram_en_cycle", fe, 1);
    chk("t1_first_m_valid_cycle", fv, 4);
    chk("t1_done_cycle", dc, 11);
    chk("t1_word_count", got.size(), 8);
    chk("t1_word0", got[0], 18'h2A5AF);
    chk("t1_word7", got[7], 18'h2A5B4);

    // Address wrap past RAM_DEPTH-1.
    run_cmd(1020, 8, 0, 60, 0, fe, fv, dc);
    chk("t2_addr_count", addr_seen.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_wrap_addr", addr_seen[i], wrap_exp[i]);
    chk("t2_word_at_1023", got[3], 18'h2A65A);
    chk("t2_word_at_0", got[4], 18'h2A5A5);

    // Zero-length command.
    run_cmd(5, 0, 0, 20, 0, fe, fv, dc);
    chk("t3_done_cycle", dc, 1);
    chk("t3_no_ram_en", fe, -1);
    chk("t3_no_m_valid", fv, -1);

    // Random backpressure.
    rnd_mode = 1'b1;
    run_cmd(200, 64, 0, 3000, 0, fe, fv, dc);
    rnd_mode = 1'b0;
    chk("t4_word_count", got.size(), 64);
    chk("t4_word0", got[0], 18'h2A56D);

    // Reset mid-command, then a fresh short command.
    run_cmd(300, 20, 0, 200, 5, fe, fv, dc);
    chk("t5_words_before_reset", got.size(), 5);
    @(posedge clka); #1 rstb = 1'b1;
    @(posedge clka); #1 rstb = 1'b0;
    @(negedge clka);
    chk("t5_rst_start_ready", start_ready, 1);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ram_en", ram_en, 0);
    chk("t5_rst_ram_addr", ram_addr, 0);
    chk("t5_rst_m_valid", m_valid, 0);
    chk("t5_rst_m_data", m_data, 0);
    chk("t5_rst_m_last", m_last, 0);
    n_bad = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clka);
      if (done || m_valid || ram_en) n_bad++;
    end
    chk("t5_quiet_after_reset", n_bad, 0);
    run_cmd(7, 3, 0, 40, 0, fe, fv, dc);
    chk("t5_post_first_valid", fv, 4);
    chk("t5_post_done_cycle", dc, 6);
    chk("t5_post_word_count", got.size(), 3);
    chk("t5_post_word2", got[2], 18'h2A5AC);

    // Low-latency instance, full throughput.
    chk("t6_start_ready", start_ready_1, 1);
    start_valid_1 = 1'b1;
    start_addr_1 = AW'(40);
    start_len_1 = LW'(16);
    @(posedge clka);
    #1 start_valid_1 = 1'b0;
    fv1 = -1; nv = 0; lastv = -1; dc1 = -1; nlast = 0; lastk = -1;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clka);
      if (m_valid_1) begin
        if (fv1 < 0) fv1 = c;
        chk("t6_data", m_data_1, memval(40 + nv));
        if (m_last_1) begin
          nlast++;
          lastk = nv;
        end
        nv++;
        lastv = c;
      end
      if (done_1 && dc1 < 0) dc1 = c;
    end
    chk("t6_first_valid_cycle", fv1, 3);
    chk("t6_valid_count", nv, 16);
    chk("t6_last_valid_cycle", lastv, 18);
    chk("t6_done_cycle", dc1, 18);
    chk("t6_last_count", nlast, 1);
    chk("t6_last_index", lastk, 15);
    chk("t6_idle_after", busy_1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: time limit reached, tests=%0d failed=%0d", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
